// File: rtl/trace_drain.sv
// trace_drain: read-side companion to the trace buffer.
// Pops one trace element at a time with a single-cycle data_request pulse,
// captures it and streams it out as a byte frame over a valid/ready link:
//   HEADER_BYTE, payload bytes LSB-first, optional XOR checksum byte.
// The next element is requested only after the current frame has drained.
//
// Build option: define TRACE_DRAIN_CHECKSUM_EN to append the checksum byte.
//
// Ports:
//   clk, rst          clock (posedge), asynchronous active-high reset
//   enable            allows new requests (sampled in idle only)
//   data_present      buffer holds at least one element
//   data_request      one-cycle pop pulse to the buffer
//   trace_element_in  element returned by the buffer
//   tx_valid/tx_data/tx_last/tx_ready  byte stream to the debug transport
//   frames_sent       completed frame count, wraps
//   busy              not idle
//
// TRACE_WIDTH should be set to the trace buffer's element width when
// instantiated.
module trace_drain #(
  parameter int unsigned TRACE_WIDTH = 32,
  parameter logic [7:0]  HEADER_BYTE = 8'hA5
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   enable,
  input  logic                   data_present,
  output logic                   data_request,
  input  logic [TRACE_WIDTH-1:0] trace_element_in,
  output logic                   tx_valid,
  output logic [7:0]             tx_data,
  output logic                   tx_last,
  input  logic                   tx_ready,
  output logic [15:0]            frames_sent,
  output logic                   busy
);

  localparam int unsigned NBYTES = (TRACE_WIDTH + 7) / 8;
  localparam int unsigned SH_W   = NBYTES * 8;
  localparam int unsigned IDX_W  = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NBYTES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_HEADER,
    S_PAYLOAD
`ifdef TRACE_DRAIN_CHECKSUM_EN
    , S_CSUM
`endif
  } state_t;

  state_t            state_q, state_d;
  logic [SH_W-1:0]   shift_q, shift_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [15:0]       frames_sent_q, frames_sent_d;
`ifdef TRACE_DRAIN_CHECKSUM_EN
  logic [7:0]        csum_q, csum_d;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_IDLE;
      shift_q       <= '0;
      idx_q         <= '0;
      frames_sent_q <= '0;
`ifdef TRACE_DRAIN_CHECKSUM_EN
      csum_q        <= '0;
`endif
    end else begin
      state_q       <= state_d;
      shift_q       <= shift_d;
      idx_q         <= idx_d;
      frames_sent_q <= frames_sent_d;
`ifdef TRACE_DRAIN_CHECKSUM_EN
      csum_q        <= csum_d;
`endif
    end
  end

  // Outputs decode from the registered state only, so an asynchronous reset
  // clears them at once and they cannot change while a byte is stalled.
  always_comb begin
    state_d       = state_q;
    shift_d       = shift_q;
    idx_d         = idx_q;
    frames_sent_d = frames_sent_q;
`ifdef TRACE_DRAIN_CHECKSUM_EN
    csum_d        = csum_q;
`endif
    data_request  = 1'b0;
    tx_valid      = 1'b0;
    tx_data       = '0;
    tx_last       = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (enable && data_present) state_d = S_REQ;
      end
      S_REQ: begin
        data_request = 1'b1;
        state_d      = S_WAIT;
      end
      S_WAIT: begin
        // Captured unconditionally: data_present may already have dropped
        // after the buffer popped its last element.
        shift_d = SH_W'(trace_element_in);
        idx_d   = '0;
`ifdef TRACE_DRAIN_CHECKSUM_EN
        csum_d  = '0;
`endif
        state_d = S_HEADER;
      end
      S_HEADER: begin
        tx_valid = 1'b1;
        tx_data  = HEADER_BYTE;
        if (tx_ready) state_d = S_PAYLOAD;
      end
      S_PAYLOAD: begin
        // The element is shifted right one byte per handshake, so the low
        // byte of the shift register is always byte[idx].
        tx_valid = 1'b1;
        tx_data  = shift_q[7:0];
`ifndef TRACE_DRAIN_CHECKSUM_EN
        tx_last  = (idx_q == LAST_IDX);
`endif
        if (tx_ready) begin
          shift_d = shift_q >> 8;
          idx_d   = idx_q + 1'b1;
`ifdef TRACE_DRAIN_CHECKSUM_EN
          csum_d  = csum_q ^ shift_q[7:0];
`endif
          if (idx_q == LAST_IDX) begin
`ifdef TRACE_DRAIN_CHECKSUM_EN
            state_d = S_CSUM;
`else
            state_d       = S_IDLE;
            frames_sent_d = frames_sent_q + 16'd1;
`endif
          end
        end
      end
`ifdef TRACE_DRAIN_CHECKSUM_EN
      S_CSUM: begin
        tx_valid = 1'b1;
        tx_data  = csum_q;
        tx_last  = 1'b1;
        if (tx_ready) begin
          state_d       = S_IDLE;
          frames_sent_d = frames_sent_q + 16'd1;
        end
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end

  assign frames_sent = frames_sent_q;
  assign busy        = (state_q != S_IDLE);

endmodule

// File: tb/tb_trace_drain.sv
module tb_trace_drain;

  localparam int unsigned TW = 20;
  localparam int unsigned NB = (TW + 7) / 8;
`ifdef TRACE_DRAIN_CHECKSUM_EN
  localparam bit CSUM_EN = 1'b1;
`else
  localparam bit CSUM_EN = 1'b0;
`endif
  localparam logic [63:0] MASK = (64'd1 << TW) - 64'd1;

  logic          clk = 1'b0;
  logic          rst;
  logic          enable;
  logic          data_present;
  logic          data_request;
  logic [TW-1:0] trace_element_in;
  logic          tx_valid;
  logic [7:0]    tx_data;
  logic          tx_last;
  logic          tx_ready;
  logic [15:0]   frames_sent;
  logic          busy;

  trace_drain #(
    .TRACE_WIDTH (TW),
    .HEADER_BYTE (8'hA5)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .enable           (enable),
    .data_present     (data_present),
    .data_request     (data_request),
    .trace_element_in (trace_element_in),
    .tx_valid         (tx_valid),
    .tx_data          (tx_data),
    .tx_last          (tx_last),
    .tx_ready         (tx_ready),
    .frames_sent      (frames_sent),
    .busy             (busy)
  );

  always #5 clk = ~clk;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model state: buffer contents and expected frame bytes.
  logic [63:0] buf_q[$];
  logic [7:0]  exp_b[$];
  bit          exp_l[$];
  logic [7:0]  obs_b[$];
  bit          pop_pending = 0;
  int unsigned frames_model = 0;
  int unsigned hs_in_frame  = 0;
  int unsigned req_count    = 0;
  int unsigned cyc          = 0;
  int unsigned last_req_cyc = 0;
  bit          have_req     = 0;
  bit          prev_req     = 0;
  bit          prev_valid   = 0;
  bit          prev_ready   = 0;
  bit          prev_last    = 0;
  logic [7:0]  prev_data    = '0;
  int unsigned ready_mode   = 0;  // 0: always ready, 1: random, 2: stall on 0xBC
  int unsigned stall_cnt    = 0;

  task automatic push_elem(input logic [63:0] e);
    buf_q.push_back(e & MASK);
    data_present = 1'b1;
  endtask

  task automatic expect_frame(input logic [63:0] e);
    logic [7:0] b;
    logic [7:0] cs;
    cs = '0;
    exp_b.push_back(8'hA5);
    exp_l.push_back(1'b0);
    for (int i = 0; i < int'(NB); i++) begin
      b = 8'((e >> (8 * i)) & 64'hFF);
      cs ^= b;
      exp_b.push_back(b);
      exp_l.push_back(!CSUM_EN && (i == int'(NB) - 1));
    end
    if (CSUM_EN) begin
      exp_b.push_back(cs);
      exp_l.push_back(1'b1);
    end
  endtask

  // One clock cycle: observe at the falling edge, then drive for the next rise.
  task automatic step();
    logic [63:0] e;
    bit r;
    @(negedge clk);
    cyc++;
    if (data_request) begin
      check_eq("req_width", prev_req, 0);
      check_eq("req_enable", enable, 1);
      check_eq("req_present", data_present, 1);
      check_eq("req_in_flight", exp_b.size(), 0);
      if (have_req) check_eq("req_spacing", (cyc - last_req_cyc) >= NB + 4, 1);
      have_req     = 1;
      last_req_cyc = cyc;
      req_count++;
    end
    if (pop_pending) begin
      e = buf_q.pop_front();
      trace_element_in = e[TW-1:0];
      expect_frame(e);
      pop_pending  = 0;
      data_present = (buf_q.size() != 0);
    end
    if (data_request) pop_pending = 1;

    if (!tx_valid) check_eq("last_without_valid", tx_last, 0);
    if (prev_valid && !prev_ready) begin
      check_eq("stall_valid", tx_valid, 1);
      check_eq("stall_data", tx_data, prev_data);
      check_eq("stall_last", tx_last, prev_last);
    end
    if (tx_valid && !prev_valid && have_req)
      check_eq("header_latency", cyc - last_req_cyc, 2);
    if (tx_valid || data_request) check_eq("busy", busy, 1);
    check_eq("frames_sent", frames_sent, frames_model);

    case (ready_mode)
      1: r = ($urandom_range(0, 99) < 60);
      2: begin
        r = !(tx_valid && tx_data == 8'hBC && stall_cnt < 3);
        if (!r) stall_cnt++;
      end
      default: r = 1'b1;
    endcase
    tx_ready = r;

    if (tx_valid) begin
      check_eq("byte_expected", exp_b.size() != 0, 1);
      if (tx_ready && exp_b.size() != 0) begin
        check_eq("tx_data", tx_data, exp_b[0]);
        check_eq("tx_last", tx_last, exp_l[0]);
        obs_b.push_back(tx_data);
        hs_in_frame++;
        if (exp_l[0]) begin
          frames_model = (frames_model + 1) % 65536;
          hs_in_frame  = 0;
        end
        void'(exp_b.pop_front());
        void'(exp_l.pop_front());
      end
    end

    prev_req   = data_request;
    prev_valid = tx_valid;
    prev_ready = tx_ready;
    prev_data  = tx_data;
    prev_last  = tx_last;
  endtask

  task automatic run_until_idle(input int unsigned max);
    int unsigned n = 0;
    while (!(exp_b.size() == 0 && buf_q.size() == 0 && !pop_pending && !busy) && n < max) begin
      step();
      n++;
    end
    check_eq("drain_timeout", n < max, 1);
  endtask

  task automatic run_until_hs(input int unsigned count, input int unsigned max);
    int unsigned n = 0;
    while (hs_in_frame < count && n < max) begin
      step();
      n++;
    end
    check_eq("hs_timeout", n < max, 1);
  endtask

  logic [7:0]  dir_exp[5];
  int unsigned r0, f0, nexp;

  initial begin
    dir_exp = '{8'hA5, 8'hDE, 8'hBC, 8'h0A, 8'h68};
    rst = 1'b1; enable = 1'b1; data_present = 1'b0; tx_ready = 1'b1;
    trace_element_in = '0;

    #3;
    check_eq("rst_data_request", data_request, 0);
    check_eq("rst_tx_valid", tx_valid, 0);
    check_eq("rst_tx_data", tx_data, 0);
    check_eq("rst_tx_last", tx_last, 0);
    check_eq("rst_frames_sent", frames_sent, 0);
    check_eq("rst_busy", busy, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Single element, sink always ready.
    r0 = req_count;
    obs_b.delete();
    push_elem(64'hABCDE);
    run_until_idle(100);
    nexp = CSUM_EN ? 5 : 4;
    check_eq("dir_len", obs_b.size(), nexp);
    for (int k = 0; k < int'(nexp); k++)
      if (k < obs_b.size()) check_eq("dir_byte", obs_b[k], dir_exp[k]);
    check_eq("dir_req_count", req_count - r0, 1);
    check_eq("dir_frames", frames_sent, 1);

    // Same element with a three-cycle stall on the 0xBC byte.
    r0 = req_count;
    ready_mode = 2; stall_cnt = 0;
    push_elem(64'hABCDE);
    run_until_idle(100);
    check_eq("stall_seen", stall_cnt, 3);
    check_eq("stall_req_count", req_count - r0, 1);
    ready_mode = 0;

    // Three queued elements back to back.
    f0 = frames_model;
    for (int k = 0; k < 3; k++) push_elem({$urandom, $urandom});
    run_until_idle(200);
    check_eq("burst_frames", frames_sent, (f0 + 3) % 65536);

    // Disabled with data waiting: no request.
    enable = 1'b0;
    r0 = req_count;
    push_elem(64'h12345);
    repeat (50) step();
    check_eq("disabled_req", req_count, r0);
    check_eq("disabled_busy", busy, 0);

    // Enable dropped mid-frame: frame completes, then idle.
    push_elem(64'h54321);
    enable = 1'b1;
    f0 = frames_model;
    run_until_hs(1, 50);
    enable = 1'b0;
    repeat (40) step();
    check_eq("en_drop_frames", frames_sent, (f0 + 1) % 65536);
    check_eq("en_drop_left", buf_q.size(), 1);
    check_eq("en_drop_busy", busy, 0);
    enable = 1'b1;
    run_until_idle(100);

    // Random traffic, random back-pressure and enable.
    ready_mode = 1;
    for (int k = 0; k < 2500; k++) begin
      step();
      if ($urandom_range(0, 99) < 5 && buf_q.size() < 4) push_elem({$urandom, $urandom});
      enable = ($urandom_range(0, 9) != 0);
    end
    enable = 1'b1;
    run_until_idle(2000);
    ready_mode = 0;

    // Reset during payload: outputs clear at once, frame abandoned.
    push_elem(64'hABCDE);
    run_until_hs(2, 50);
    rst = 1'b1;
    #1;
    check_eq("mid_rst_valid", tx_valid, 0);
    check_eq("mid_rst_last", tx_last, 0);
    check_eq("mid_rst_busy", busy, 0);
    check_eq("mid_rst_frames", frames_sent, 0);
    check_eq("mid_rst_req", data_request, 0);
    exp_b.delete(); exp_l.delete(); buf_q.delete();
    pop_pending = 0; frames_model = 0; hs_in_frame = 0;
    have_req = 0; prev_req = 0; prev_valid = 0; prev_ready = 0;
    data_present = 1'b0;
    @(posedge clk);
    #1;
    check_eq("rst_hold_valid", tx_valid, 0);
    rst = 1'b0;
    obs_b.delete();
    push_elem(64'h13579);
    run_until_idle(100);
    check_eq("post_rst_len", obs_b.size(), NB + 1 + (CSUM_EN ? 1 : 0));
    if (obs_b.size() != 0) check_eq("post_rst_header", obs_b[0], 8'hA5);
    check_eq("post_rst_frames", frames_sent, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
